hazard_redirect_ctrl: RTL and testbench
=======================================

Name: hazard_redirect_ctrl

Overview:
- Pipeline interlock and redirect controller for the 5-stage MIPS redirection pipeline with BTB.
- Sits directly downstream of the hazard-request OR reduction and consumes its single "any hazard" result.
- Combines that result with EX-stage BTB mispredict and syscall halt to drive PC/IF-ID enables, IF-ID/ID-EX flushes and the PC redirect.
- Maintains a RUN/HALT state machine and cycle/stall/flush performance counters.

Parameters:
- PC_W, 32, width of PC and redirect target.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_req  in  1  OR-reduced hazard request (load-use, etc.) for the current cycle.
- ex_mispredict  in  1  EX stage reports BTB mispredict this cycle.
- ex_target  in  PC_W  correct next PC from EX, valid with ex_mispredict.
- halt_req  in  1  syscall halt decoded in EX.
- go  in  1  resume level input; only a rising edge has effect.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to bubble.
- idex_flush  out  1  clear ID/EX to bubble.
- redirect_valid  out  1  PC mux selects redirect_pc.
- redirect_pc  out  PC_W  redirect target.
- halted  out  1  state is HALT.
- cycle_cnt  out  CNT_W  RUN cycles.
- stall_cnt  out  CNT_W  stall cycles.
- flush_cnt  out  CNT_W  mispredict flushes.

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset:
  - state = RUN, go edge register = 0, all counters = 0.
  - Outputs while in RUN with no requests: pc_en=1, ifid_en=1, flushes=0, redirect_valid=0, redirect_pc=0, halted=0.
- Control outputs are combinational from the current state and inputs, with zero latency. The state and counters are registered.
- Priority in RUN: mispredict > stall > normal.
- Mispredict (ex_mispredict=1):
  - redirect_valid=1, redirect_pc=ex_target.
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - stall_req is ignored this cycle, because the hazarding instruction is on the wrong path.
- Stall (stall_req=1, no mispredict): pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, redirect_valid=0.
- When redirect_valid=0, redirect_pc=0.
- State machine RUN -> HALT: on halt_req=1 with ex_mispredict=0. Control outputs in that cycle are as for RUN; halted asserts next cycle.
- halt_req together with ex_mispredict: halt is dropped and the mispredict is serviced.
- HALT state:
  - pc_en=0, ifid_en=0, all flushes=0, redirect_valid=0, halted=1.
  - ex_mispredict, stall_req and halt_req are ignored.
- State machine HALT -> RUN: on a go rising edge, i.e. go=1 with the registered previous go=0. go stays sampled in all states.
- A go edge while in RUN has no effect.
- Counters, updated at the clock edge:
  - cycle_cnt increments every RUN cycle.
  - stall_cnt increments on stall cycles.
  - flush_cnt increments on mispredict cycles.
  - All counters saturate at all-ones and never wrap.
- Reset asserted mid-operation (including in HALT or mid-stall) returns everything to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: the three counters are implemented as specified.
- Undefined: the counter registers are not built, and cycle_cnt, stall_cnt and flush_cnt are tied to 0.
- Control behaviour is identical in both builds.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding: ST_RUN=1'b0, ST_HALT=1'b1.
  - defaults for PC_W and CNT_W.
- One sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output q). It is instantiated three times under HAZARD_PERF_CNT_EN.

Test Plan:
- Reset then idle 10 cycles -> pc_en=1, ifid_en=1, flushes=0, cycle_cnt=10, stall_cnt=0, flush_cnt=0.
- stall_req=1 for 2 cycles -> pc_en=0, ifid_en=0, idex_flush=1 in both cycles; stall_cnt=2.
- ex_mispredict=1, ex_target=0x00400040, stall_req=1 same cycle -> redirect_valid=1, redirect_pc=0x00400040, both flushes=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- halt_req=1 -> halted=1 next cycle. Then go held at 1 for 5 cycles after it was already 1 entering HALT -> stays HALT. go 0 then 1 -> RUN next cycle; cycle_cnt frozen during HALT.
- halt_req=1 with ex_mispredict=1 -> halt dropped, remains RUN, redirect serviced.
- Preload stall_cnt near saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15. rst_n low mid-stall, asynchronous to clk -> all counters 0 and pc_en=1 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default widths for the hazard/redirect controller.
package hazard_pkg;
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam int PC_W_DEF  = 32;
   localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt_q <= '0;
      else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
   end

   assign q = cnt_q;
endmodule

// File: rtl/hazard_redirect_ctrl.sv
// Pipeline interlock / redirect controller with RUN/HALT state machine.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_redirect_ctrl
   import hazard_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_req,
   input  logic             ex_mispredict,
   input  logic [PC_W-1:0]  ex_target,
   input  logic             halt_req,
   input  logic             go,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   state_e state_q, state_d;
   logic   go_q;
   logic   go_rise;

   assign go_rise = go && !go_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go;
      end
   end

   // While reset is held the control outputs show the idle RUN values,
   // even if a stall request is still present on the inputs.
   always_comb begin
      state_d        = state_q;
      pc_en          = 1'b1;
      ifid_en        = 1'b1;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (rst_n) begin
         case (state_q)
            ST_RUN: begin
               if (ex_mispredict) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = ex_target;
                  ifid_flush     = 1'b1;
                  idex_flush     = 1'b1;
               end else begin
                  if (stall_req) begin
                     pc_en      = 1'b0;
                     ifid_en    = 1'b0;
                     idex_flush = 1'b1;
                  end
                  if (halt_req) state_d = ST_HALT;
               end
            end
            ST_HALT: begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               if (go_rise) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign halted = (state_q == ST_HALT);

`ifdef HAZARD_PERF_CNT_EN
   logic run_cyc, stall_cyc, flush_cyc;
   assign run_cyc   = (state_q == ST_RUN);
   assign stall_cyc = run_cyc && !ex_mispredict && stall_req;
   assign flush_cyc = run_cyc && ex_mispredict;

   sat_counter #(.W(CNT_W)) u_cycle_cnt (.clk(clk), .rst_n(rst_n), .inc(run_cyc),   .q(cycle_cnt));
   sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall_cyc), .q(stall_cnt));
   sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush_cyc), .q(flush_cnt));
`else
   assign cycle_cnt = '0;
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Directed bench for hazard_redirect_ctrl; a second 4-bit-counter instance covers saturation.
module tb_hazard_redirect_ctrl;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_req, ex_mispredict, halt_req, go;
   logic [31:0] ex_target;

   logic        pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, halted;
   logic [31:0] redirect_pc, cycle_cnt, stall_cnt, flush_cnt;

   logic        pc_en4, ifid_en4, ifid_flush4, idex_flush4, redirect_valid4, halted4;
   logic [31:0] redirect_pc4;
   logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   hazard_redirect_ctrl #(.PC_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .ex_mispredict(ex_mispredict),
      .ex_target(ex_target), .halt_req(halt_req), .go(go),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
      .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   hazard_redirect_ctrl #(.PC_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .ex_mispredict(ex_mispredict),
      .ex_target(ex_target), .halt_req(halt_req), .go(go),
      .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
      .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4), .halted(halted4),
      .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

   task automatic test_reset();
      rst_n = 1'b0; stall_req = 0; ex_mispredict = 0; halt_req = 0; go = 0; ex_target = '0;
      #12;
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, halted} !== 6'b110000) begin
         fails++; $display("FAIL reset_ctrl got=%b exp=110000",
            {pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid, halted});
      end
      checks++;
      if (redirect_pc !== 32'h0 || cycle_cnt !== 32'h0 || stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
         fails++; $display("FAIL reset_vals pc=%h cyc=%0d stl=%0d fl=%0d exp all 0",
            redirect_pc, cycle_cnt, stall_cnt, flush_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1100) begin
         fails++; $display("FAIL idle_ctrl got=%b exp=1100", {pc_en, ifid_en, ifid_flush, idex_flush});
      end
      checks++;
      if (cycle_cnt !== (PERF ? 32'd10 : 32'd0) || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         fails++; $display("FAIL idle_cnt cyc=%0d stl=%0d fl=%0d exp cyc=%0d stl=0 fl=0",
            cycle_cnt, stall_cnt, flush_cnt, PERF ? 10 : 0);
      end
   endtask

   task automatic test_stall();
      stall_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid} !== 5'b00010) begin
            fails++; $display("FAIL stall_ctrl%0d got=%b exp=00010", i,
               {pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid});
         end
         @(negedge clk);
      end
      stall_req = 1'b0;
      checks++;
      if (stall_cnt !== (PERF ? 32'd2 : 32'd0) || cycle_cnt !== (PERF ? 32'd12 : 32'd0)) begin
         fails++; $display("FAIL stall_cnt stl=%0d cyc=%0d exp stl=%0d cyc=%0d",
            stall_cnt, cycle_cnt, PERF ? 2 : 0, PERF ? 12 : 0);
      end
   endtask

   task automatic test_mispredict();
      ex_target = 32'h0000_dead; #1;
      checks++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
         fails++; $display("FAIL no_redirect rv=%b pc=%h exp rv=0 pc=0", redirect_valid, redirect_pc);
      end
      ex_mispredict = 1'b1; ex_target = 32'h0040_0040; stall_req = 1'b1; #1;
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid} !== 5'b11111 ||
          redirect_pc !== 32'h0040_0040) begin
         fails++; $display("FAIL mispredict ctrl=%b pc=%h exp ctrl=11111 pc=00400040",
            {pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid}, redirect_pc);
      end
      @(negedge clk);
      ex_mispredict = 0; stall_req = 0; ex_target = '0;
      checks++;
      if (flush_cnt !== (PERF ? 32'd1 : 32'd0) || stall_cnt !== (PERF ? 32'd2 : 32'd0) ||
          cycle_cnt !== (PERF ? 32'd13 : 32'd0)) begin
         fails++; $display("FAIL mispredict_cnt fl=%0d stl=%0d cyc=%0d exp fl=%0d stl=%0d cyc=%0d",
            flush_cnt, stall_cnt, cycle_cnt, PERF ? 1 : 0, PERF ? 2 : 0, PERF ? 13 : 0);
      end
   endtask

   task automatic test_halt();
      halt_req = 1'b1; go = 1'b1; #1;
      checks++;
      if (halted !== 1'b0 || pc_en !== 1'b1) begin
         fails++; $display("FAIL halt_req_cycle halted=%b pc_en=%b exp 0 1", halted, pc_en);
      end
      @(negedge clk);
      halt_req = 1'b0; stall_req = 1'b1; ex_mispredict = 1'b1; ex_target = 32'h1111_2222; #1;
      checks++;
      if ({halted, pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid} !== 6'b100000 ||
          redirect_pc !== 32'h0) begin
         fails++; $display("FAIL halt_ctrl got=%b pc=%h exp=100000 pc=0",
            {halted, pc_en, ifid_en, ifid_flush, idex_flush, redirect_valid}, redirect_pc);
      end
      repeat (5) @(negedge clk);
      stall_req = 0; ex_mispredict = 0; ex_target = '0;
      checks++;
      if (halted !== 1'b1) begin
         fails++; $display("FAIL halt_go_level halted=%b exp=1", halted);
      end
      checks++;
      if (cycle_cnt !== (PERF ? 32'd14 : 32'd0) || stall_cnt !== (PERF ? 32'd2 : 32'd0) ||
          flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin
         fails++; $display("FAIL halt_frozen cyc=%0d stl=%0d fl=%0d exp cyc=%0d stl=%0d fl=%0d",
            cycle_cnt, stall_cnt, flush_cnt, PERF ? 14 : 0, PERF ? 2 : 0, PERF ? 1 : 0);
      end
      go = 1'b0;
      @(negedge clk) go = 1'b1; #1;
      checks++;
      if (halted !== 1'b1) begin
         fails++; $display("FAIL go_edge_same_cycle halted=%b exp=1", halted);
      end
      @(negedge clk);
      checks++;
      if (halted !== 1'b0 || pc_en !== 1'b1 || cycle_cnt !== (PERF ? 32'd14 : 32'd0)) begin
         fails++; $display("FAIL resume halted=%b pc_en=%b cyc=%0d exp 0 1 %0d",
            halted, pc_en, cycle_cnt, PERF ? 14 : 0);
      end
      go = 1'b0;
      @(negedge clk) go = 1'b1;
      repeat (2) @(negedge clk);
      go = 1'b0;
      checks++;
      if (halted !== 1'b0 || cycle_cnt !== (PERF ? 32'd17 : 32'd0)) begin
         fails++; $display("FAIL go_in_run halted=%b cyc=%0d exp 0 %0d", halted, cycle_cnt, PERF ? 17 : 0);
      end
   endtask

   task automatic test_halt_mispredict();
      halt_req = 1'b1; ex_mispredict = 1'b1; ex_target = 32'h0000_1234; #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1234 || pc_en !== 1'b1) begin
         fails++; $display("FAIL halt_mis_ctrl rv=%b pc=%h pc_en=%b exp 1 00001234 1",
            redirect_valid, redirect_pc, pc_en);
      end
      @(negedge clk);
      halt_req = 0; ex_mispredict = 0; ex_target = '0; #1;
      checks++;
      if (halted !== 1'b0 || flush_cnt !== (PERF ? 32'd2 : 32'd0)) begin
         fails++; $display("FAIL halt_mis_state halted=%b fl=%0d exp 0 %0d", halted, flush_cnt, PERF ? 2 : 0);
      end
   endtask

   task automatic test_saturation_reset();
      @(negedge clk) stall_req = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (stall_cnt4 !== (PERF ? 4'd15 : 4'd0) || cycle_cnt4 !== (PERF ? 4'd15 : 4'd0)) begin
         fails++; $display("FAIL sat4 stl=%0d cyc=%0d exp %0d %0d",
            stall_cnt4, cycle_cnt4, PERF ? 15 : 0, PERF ? 15 : 0);
      end
      checks++;
      if (stall_cnt !== (PERF ? 32'd22 : 32'd0)) begin
         fails++; $display("FAIL sat32 stl=%0d exp %0d", stall_cnt, PERF ? 22 : 0);
      end
      #2 rst_n = 1'b0; #1;
      checks++;
      if (pc_en !== 1'b1 || idex_flush !== 1'b0 || stall_cnt !== 32'd0 || cycle_cnt !== 32'd0 ||
          flush_cnt !== 32'd0 || stall_cnt4 !== 4'd0 || pc_en4 !== 1'b1) begin
         fails++; $display("FAIL async_rst_stall pc_en=%b idex=%b stl=%0d cyc=%0d fl=%0d stl4=%0d exp 1 0 0 0 0 0",
            pc_en, idex_flush, stall_cnt, cycle_cnt, flush_cnt, stall_cnt4);
      end
      stall_req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      halt_req = 1'b1;
      @(negedge clk) halt_req = 1'b0;
      checks++;
      if (halted !== 1'b1) begin
         fails++; $display("FAIL halt_before_rst halted=%b exp=1", halted);
      end
      #3 rst_n = 1'b0; #1;
      checks++;
      if (halted !== 1'b0 || pc_en !== 1'b1 || ifid_en !== 1'b1) begin
         fails++; $display("FAIL async_rst_halt halted=%b pc_en=%b ifid_en=%b exp 0 1 1", halted, pc_en, ifid_en);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_mispredict();
      test_halt();
      test_halt_mispredict();
      test_saturation_reset();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
